// File: rtl/wb_regmap_pkg.sv
// Shared constants for the Wishbone register-map / loop-back FIFO endpoint:
// cycle-type codes, interrupt bit positions, default address map, bus FSM states.
package wb_regmap_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int IS_OVF    = 0;
  localparam int IS_UNF    = 1;
  localparam int IS_BUSERR = 2;
  localparam int IS_NEMPTY = 3;

  localparam int DEF_A_POP     = 16;
  localparam int DEF_A_PUSH    = 17;
  localparam int DEF_A_STATUS  = 18;
  localparam int DEF_A_INTEN   = 19;
  localparam int DEF_A_INTSTAT = 20;

  // ST_BURST: inside a cti 001/010 cycle, beats use the internal address counter.
  // ST_TERM: a terminal ack/err is on the bus; nothing is accepted this edge.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_TERM  = 2'd2
  } bus_state_t;

  function automatic logic is_burst_cti(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

endpackage

// File: rtl/wb_regmap_fifo_if.sv
// Wishbone B4 bus bundle between the host bridge (master) and the register-map endpoint (slave).
interface wb_regmap_fifo_if #(
  parameter int DW = 16,
  parameter int AW = 5
);
  import wb_regmap_pkg::*;

  // Handshake: a beat transfers on a rising edge where cyc & stb are high and no
  // terminal response is showing; ack (or err) is registered and is high during
  // the cycle after that edge, with read data valid alongside it. In a burst the
  // master presents the next beat as soon as it sees ack, so ack stays high.
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_i;
  logic [2:0]      wb_cti_i;
  logic            wb_we_i;
  logic            wb_stb_i;
  logic            wb_cyc_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_int_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_int_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_int_o
  );

endinterface

// File: rtl/wb_fifo_fwft.sv
// First-word-fall-through FIFO: dout always shows the head word; pop advances it.
module wb_fifo_fwft
  import wb_regmap_pkg::*;
#(
  parameter int DW      = 16,
  parameter int FIFO_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [DW-1:0]      din,
  output logic [DW-1:0]      dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               wr_en, rd_en;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  // Storage is not reset: only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_regmap_fifo.sv
// Wishbone B4 slave: RW register file, loop-back FIFO, status and sticky interrupt
// registers, with classic/const-burst/incr-burst support and registered ack/err.
module wb_regmap_fifo
  import wb_regmap_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 5,
  parameter int NREGS     = 8,
  parameter int FIFO_AW   = 10,
  parameter int A_POP     = DEF_A_POP,
  parameter int A_PUSH    = DEF_A_PUSH,
  parameter int A_STATUS  = DEF_A_STATUS,
  parameter int A_INTEN   = DEF_A_INTEN,
  parameter int A_INTSTAT = DEF_A_INTSTAT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  wb_regmap_fifo_if.slave wb,
  output bus_state_t      dbg_state
);
  localparam int SW  = DW / 8;
  localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW-1:0] NREGS_A     = AW'(NREGS);
  localparam logic [AW-1:0] A_POP_A     = AW'(A_POP);
  localparam logic [AW-1:0] A_PUSH_A    = AW'(A_PUSH);
  localparam logic [AW-1:0] A_STATUS_A  = AW'(A_STATUS);
  localparam logic [AW-1:0] A_INTEN_A   = AW'(A_INTEN);
  localparam logic [AW-1:0] A_INTSTAT_A = AW'(A_INTSTAT);

  bus_state_t        state_q, state_d;
  logic [AW-1:0]     adr_q, beat_adr;
  logic [DW-1:0]     regs_q [NREGS];
  logic [3:0]        inten_q;
  logic [2:0]        ist_q, ist_d;
  logic              ack_q, err_q, int_q;
  logic [DW-1:0]     dat_q, rd_data, status_w, intstat_w;
  logic              accept, wr_ok;
  logic              err_ovf, err_unf, err_oth, bus_err;
  logic              hit_reg, hit_pop, hit_push, hit_inten, hit_intstat;
  logic              f_push, f_pop, f_full, f_empty;
  logic [DW-1:0]     f_dout;
  logic [FIFO_AW:0]  f_count;

  wb_fifo_fwft #(.DW(DW), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (f_push),
    .pop   (f_pop),
    .din   (wb.wb_dat_i),
    .dout  (f_dout),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  // After the first beat of a burst the address comes from the internal counter,
  // so read data for the next beat does not wait for the master to update adr.
  assign accept   = wb.wb_cyc_i & wb.wb_stb_i & (state_q != ST_TERM);
  assign beat_adr = (state_q == ST_BURST) ? adr_q : wb.wb_adr_i;

  always_comb begin
    status_w = '0;
    status_w[FIFO_AW+2:0] = {f_count, f_full, f_empty};
    intstat_w = '0;
    intstat_w[2:0] = ist_q;
    intstat_w[IS_NEMPTY] = ~f_empty;
  end

  always_comb begin
    hit_reg     = 1'b0;
    hit_pop     = 1'b0;
    hit_push    = 1'b0;
    hit_inten   = 1'b0;
    hit_intstat = 1'b0;
    err_ovf     = 1'b0;
    err_unf     = 1'b0;
    err_oth     = 1'b0;
    rd_data     = '0;
    if (beat_adr < NREGS_A) begin
      hit_reg = 1'b1;
      rd_data = regs_q[beat_adr[RIW-1:0]];
    end else if (beat_adr == A_POP_A) begin
      if (wb.wb_we_i)   err_oth = 1'b1;
      else if (f_empty) err_unf = 1'b1;
      else begin
        hit_pop = 1'b1;
        rd_data = f_dout;
      end
    end else if (beat_adr == A_PUSH_A) begin
      if (!wb.wb_we_i) err_oth  = 1'b1;
      else if (f_full) err_ovf  = 1'b1;
      else             hit_push = 1'b1;
    end else if (beat_adr == A_STATUS_A) begin
      if (wb.wb_we_i) err_oth = 1'b1;
      else            rd_data = status_w;
    end else if (beat_adr == A_INTEN_A) begin
      hit_inten    = 1'b1;
      rd_data[3:0] = inten_q;
    end else if (beat_adr == A_INTSTAT_A) begin
      hit_intstat = 1'b1;
      rd_data     = intstat_w;
    end else begin
      err_oth = 1'b1;
    end
    bus_err = err_ovf | err_unf | err_oth;
  end

  assign wr_ok  = accept & wb.wb_we_i & ~bus_err;
  assign f_push = accept & hit_push;
  assign f_pop  = accept & hit_pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_BURST: begin
        if (!wb.wb_cyc_i)
          state_d = ST_IDLE;
        else if (accept)
          state_d = (bus_err || !is_burst_cti(wb.wb_cti_i)) ? ST_TERM : ST_BURST;
      end
      ST_TERM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Sticky bits: a clear and a new event on the same edge leave the bit set.
  always_comb begin
    ist_d = ist_q;
    if (wr_ok && hit_intstat && wb.wb_sel_i[0]) ist_d = ist_q & ~wb.wb_dat_i[2:0];
    if (accept && err_ovf) ist_d[IS_OVF]    = 1'b1;
    if (accept && err_unf) ist_d[IS_UNF]    = 1'b1;
    if (accept && err_oth) ist_d[IS_BUSERR] = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      adr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      int_q   <= 1'b0;
      inten_q <= '0;
      ist_q   <= '0;
    end else begin
      ack_q <= accept & ~bus_err;
      err_q <= accept & bus_err;
      dat_q <= (accept && !wb.wb_we_i && !bus_err) ? rd_data : '0;
      if (accept) adr_q <= beat_adr + AW'(wb.wb_cti_i == CTI_INCR);
      if (wr_ok && hit_inten && wb.wb_sel_i[0]) inten_q <= wb.wb_dat_i[3:0];
      ist_q <= ist_d;
      int_q <= |(intstat_w[3:0] & inten_q);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok && hit_reg) begin
      for (int b = 0; b < SW; b++)
        if (wb.wb_sel_i[b]) regs_q[beat_adr[RIW-1:0]][b*8 +: 8] <= wb.wb_dat_i[b*8 +: 8];
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_int_o = int_q;
  assign dbg_state   = state_q;

endmodule
